dac_soft_mute: RTL and testbench
================================

# dac_soft_mute

Output conditioning stage between the interpolator output (18-bit two's-complement, one sample per clock) and the 14-bit DAC pins. Applies a linear gain ramp for click-free mute/unmute, rounds and saturates to DAC width, and selects two's-complement or offset-binary coding. Fixed 3-cycle pipeline; the mute state machine runs every clock.

## Interface
- RAMP_LOG2, default 10: ramp length is 2^RAMP_LOG2 clocks, from zero to full gain.
- DW_IN, default 18: input sample width.
- DW_OUT, default 14: DAC word width.
- clk  in  1  system clock; every edge is a sample.
- resetN  in  1  asynchronous, active-low reset.
- mute  in  1  level; 1 requests ramp to silence, 0 requests ramp to full gain.
- offsetBinary  in  1  1: dataOut MSB inverted (offset binary); 0: two's complement.
- clrSat  in  1  single-cycle clear of satFlag.
- dataIn  in  DW_IN  signed sample from interpolator output.
- dataOut  out  DW_OUT  registered DAC word.
- muted  out  1  1 while FSM is in MUTED.
- satFlag  out  1  sticky; set by any rounding saturation.

## Operation
- Gain register g: RAMP_LOG2+1 bits, range 0..2^RAMP_LOG2; full scale = 2^RAMP_LOG2.
- FSM states: MUTED (g=0), RAMP_UP, UNMUTED (g=full), RAMP_DOWN.
- MUTED -> RAMP_UP when mute=0. RAMP_UP: g+1 per clock; -> UNMUTED on the clock g reaches full.
- UNMUTED -> RAMP_DOWN when mute=1. RAMP_DOWN: g-1 per clock; -> MUTED on the clock g reaches 0.
- Reversal: mute=1 in RAMP_UP -> RAMP_DOWN from current g; mute=0 in RAMP_DOWN -> RAMP_UP from current g. No jumps in g, no extra hold cycle.
- Stage 1: p = signed(dataIn) * unsigned(g), registered, DW_IN+RAMP_LOG2+1 bits.
- Stage 2: s = p >>> RAMP_LOG2 (arithmetic, floor); at full gain s == dataIn exactly. Round: r = s + 2^(DW_IN-DW_OUT-1), keep r >> (DW_IN-DW_OUT). If result exceeds +2^(DW_OUT-1)-1, clamp to it and pulse sat. Negative overflow cannot occur and needs no logic.
- Stage 3: dataOut = rounded word, MSB inverted when offsetBinary=1. offsetBinary is sampled in stage 3 only.
- satFlag: set on stage-2 sat pulse, cleared by clrSat. Set wins if both occur in the same cycle.

## Timing
- Reset (resetN low, async): FSM=MUTED, g=0, all pipeline registers 0, dataOut=0, muted=1, satFlag=0.
- First clock after release: stage 3 loads a zero sample in the selected coding, i.e. 0x0000, or 0x2000 when offsetBinary=1.
- Latency dataIn -> dataOut: 3 clocks. The g applied is the value held in the cycle dataIn is sampled.
- mute sampled every clock. With mute=0 from reset release: g=1 after clock 1, full after clock 2^RAMP_LOG2. muted falls on clock 1 (state RAMP_UP).
- Full ramp in either direction: exactly 2^RAMP_LOG2 clocks.
- resetN asserted mid-ramp: immediate return to MUTED with g=0; the pipeline is cleared asynchronously.

## Test plan
- Reset/ramp-up (RAMP_LOG2=4, mute=0, dataIn=0x10000) -> muted 1→0 on clock 1; dataOut reaches 0x1000 exactly 16+3 clocks after release; monotonic non-decreasing on the way.
- Half gain: hold g=8 of 16 (mute=1 at g=8, compare the first output) with dataIn=0x10000 -> dataOut 0x0800; dataIn=0x30000 (-65536) -> 0x3800.
- Rounding/saturation at full gain: dataIn 0x1FFF0 → 0x1FFF, satFlag stays 0; 0x1FFFF → 0x1FFF, satFlag 1; 0x20000 → 0x2000. Same samples with offsetBinary=1 → 0x3FFF, 0x3FFF, 0x0000.
- Reversal: mute=1 at g=10 during RAMP_UP -> g 9,8,…,0 with no repeated value; MUTED (muted=1) after 10 clocks.
- Sticky flag: sat event and clrSat in the same cycle -> satFlag=1; clrSat alone next cycle -> 0.
- Async reset mid-ramp at g=7 -> dataOut=0, muted=1, g=0 without a clock edge; a fresh ramp starts cleanly after release.

Source files
------------

// File: rtl/dac_soft_mute_if.sv
// dac_soft_mute_if
//   Bundles the sample stream and control/status signals of dac_soft_mute.
//   Streaming, no valid/ready: every clock edge moves one sample in and one
//   DAC word out, so there is no handshake and no backpressure.
//
//   Signals (direction as seen by the DUT, i.e. the slave modport):
//     mute          in   1         1 = ramp to silence, 0 = ramp to full gain
//     offsetBinary  in   1         1 = offset-binary dataOut, 0 = two's complement
//     clrSat        in   1         single-cycle clear of satFlag
//     dataIn        in   DW_IN     signed interpolator sample
//     dataOut       out  DW_OUT    registered DAC word
//     muted         out  1         high while the FSM is in MUTED
//     satFlag       out  1         sticky saturation flag
//     stateDbg      out  2         current FSM state (debug)
//     gainDbg       out  RAMP_LOG2+1  current gain register (debug)
interface dac_soft_mute_if #(
    parameter int RAMP_LOG2 = 10,
    parameter int DW_IN     = 18,
    parameter int DW_OUT    = 14
);
    logic                 mute;
    logic                 offsetBinary;
    logic                 clrSat;
    logic [DW_IN-1:0]     dataIn;
    logic [DW_OUT-1:0]    dataOut;
    logic                 muted;
    logic                 satFlag;
    logic [1:0]           stateDbg;
    logic [RAMP_LOG2:0]   gainDbg;

    modport master (
        output mute, offsetBinary, clrSat, dataIn,
        input  dataOut, muted, satFlag, stateDbg, gainDbg
    );

    modport slave (
        input  mute, offsetBinary, clrSat, dataIn,
        output dataOut, muted, satFlag, stateDbg, gainDbg
    );
endinterface

// File: rtl/dac_soft_mute.sv
// dac_soft_mute
//   Output conditioning between the interpolator and the DAC pins: linear
//   gain ramp for click-free mute/unmute, round-and-saturate from DW_IN to
//   DW_OUT bits, and two's-complement / offset-binary output coding.
//   Fixed 3-cycle pipeline: multiply -> scale/round/saturate -> coding.
//
//   Ports:
//     clk     in  system clock, one sample per edge
//     resetN  in  asynchronous active-low reset
//     bus     dac_soft_mute_if.slave (sample stream, control, status, debug)
module dac_soft_mute #(
    parameter int RAMP_LOG2 = 10,
    parameter int DW_IN     = 18,
    parameter int DW_OUT    = 14
) (
    input  logic                 clk,
    input  logic                 resetN,
    dac_soft_mute_if.slave       bus
);
    localparam int GW = RAMP_LOG2 + 1;          // gain register width
    localparam int PW = DW_IN + RAMP_LOG2 + 1;  // product width
    localparam int SH = DW_IN - DW_OUT;         // rounding shift

    localparam logic [1:0] S_MUTED     = 2'd0;
    localparam logic [1:0] S_RAMP_UP   = 2'd1;
    localparam logic [1:0] S_UNMUTED   = 2'd2;
    localparam logic [1:0] S_RAMP_DOWN = 2'd3;

    localparam logic [GW-1:0]        FULL_GAIN  = GW'(1) << RAMP_LOG2;
    localparam logic signed [DW_IN:0] ROUND_BIAS = (DW_IN+1)'(1) << (SH-1);
    localparam logic [DW_OUT-1:0]    MAX_POS    = {1'b0, {(DW_OUT-1){1'b1}}};

    logic [1:0]               state, stateNext;
    logic [GW-1:0]            gain, gainNext;
    logic signed [PW-1:0]     dataExt, gainExt, prodFull, prodReg;
    logic signed [DW_IN:0]    scaled, roundedWide;
    logic                     overflow;
    logic [DW_OUT-1:0]        roundedWord, stage2Word, dataOutReg;
    logic                     satReg;
    logic                     unusedBits;

    // Gain walks one step per clock toward the requested end point. The
    // state follows from where the gain lands, so a reversal mid-ramp just
    // changes direction from the current value with no hold cycle.
    always_comb begin
        gainNext = gain;
        if (!bus.mute) begin
            if (gain != FULL_GAIN) gainNext = gain + GW'(1);
        end else begin
            if (gain != '0) gainNext = gain - GW'(1);
        end

        if (gainNext == '0)            stateNext = S_MUTED;
        else if (gainNext == FULL_GAIN) stateNext = S_UNMUTED;
        else if (bus.mute)             stateNext = S_RAMP_DOWN;
        else                           stateNext = S_RAMP_UP;
    end

    // Stage 1 operands: signed sample times unsigned gain, both widened to
    // the product width so the multiply is exact modulo 2^PW. |p| never
    // exceeds 2^(DW_IN-1) * 2^RAMP_LOG2, so nothing is lost.
    assign dataExt  = PW'($signed(bus.dataIn));
    assign gainExt  = $signed(PW'(gain));
    assign prodFull = dataExt * gainExt;

    // Stage 2: arithmetic shift by RAMP_LOG2 (floor), so full gain returns
    // the input unchanged; then round half up and drop SH bits. Only the
    // positive side can overflow (+max rounding up), detected where the
    // two top bits of the widened sum disagree.
    assign scaled      = prodReg[PW-1:RAMP_LOG2];
    assign roundedWide = scaled + ROUND_BIAS;
    assign overflow    = roundedWide[DW_IN-1] & ~roundedWide[DW_IN];
    assign roundedWord = overflow ? MAX_POS : roundedWide[DW_IN-1:SH];

    // Bits discarded by design (fractional parts of shift and rounding).
    assign unusedBits = ^{prodReg[RAMP_LOG2-1:0], roundedWide[SH-1:0]};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= S_MUTED;
            gain       <= '0;
            prodReg    <= '0;
            stage2Word <= '0;
            dataOutReg <= '0;
            satReg     <= 1'b0;
        end else begin
            state      <= stateNext;
            gain       <= gainNext;
            prodReg    <= prodFull;
            stage2Word <= roundedWord;
            // Offset binary is two's complement with the MSB flipped.
            dataOutReg <= {stage2Word[DW_OUT-1] ^ bus.offsetBinary,
                           stage2Word[DW_OUT-2:0]};
            // Set has priority over clear.
            if (overflow)        satReg <= 1'b1;
            else if (bus.clrSat) satReg <= 1'b0;
        end
    end

    assign bus.dataOut  = dataOutReg;
    assign bus.muted    = (state == S_MUTED);
    assign bus.satFlag  = satReg;
    assign bus.stateDbg = state;
    assign bus.gainDbg  = gain;
endmodule

// File: tb/tb_dac_soft_mute.sv
// tb_dac_soft_mute
//   Directed bench for dac_soft_mute with RAMP_LOG2=4 (16-clock ramps).
//   Expected values are hand-computed from the transfer function:
//   out = round(floor(in*g/16) / 16), saturated to 14 bits.
module tb_dac_soft_mute;
    localparam int RAMP_LOG2 = 4;
    localparam int DW_IN     = 18;
    localparam int DW_OUT    = 14;

    logic clk = 1'b0;
    logic resetN;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [31:0] expQ[$];

    dac_soft_mute_if #(.RAMP_LOG2(RAMP_LOG2), .DW_IN(DW_IN), .DW_OUT(DW_OUT)) bus ();

    dac_soft_mute #(.RAMP_LOG2(RAMP_LOG2), .DW_IN(DW_IN), .DW_OUT(DW_OUT)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkEq(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Rounding/saturation vectors at full gain.
    logic [17:0] vIn    [6] = '{18'h1FFF0, 18'h20000, 18'h1FFFF, 18'h1FFF0, 18'h20000, 18'h1FFFF};
    logic        vOb    [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] vOut   [6] = '{32'h1FFF, 32'h2000, 32'h1FFF, 32'h3FFF, 32'h0000, 32'h3FFF};
    logic [31:0] vSat   [6] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1};

    initial begin
        // ---------------- reset ----------------
        resetN           = 1'b1;
        bus.mute         = 1'b0;
        bus.dataIn       = 18'h10000;
        bus.offsetBinary = 1'b0;
        bus.clrSat       = 1'b0;
        #1 resetN = 1'b0;
        #2;
        checkEq("rst_dataOut", 32'(bus.dataOut), 32'h0);
        checkEq("rst_muted",   32'(bus.muted),   32'd1);
        checkEq("rst_satFlag", 32'(bus.satFlag), 32'd0);
        checkEq("rst_gain",    32'(bus.gainDbg), 32'd0);
        tick();
        tick();
        resetN = 1'b1;

        // ---------------- ramp up: out at clock n = 256*(n-3) ----------------
        for (int n = 1; n <= 19; n++) begin
            tick();
            checkEq("ramp_dataOut", 32'(bus.dataOut), (n <= 3) ? 32'd0 : 32'(256 * (n - 3)));
            if (n == 1) begin
                checkEq("ramp_muted_c1", 32'(bus.muted),   32'd0);
                checkEq("ramp_gain_c1",  32'(bus.gainDbg), 32'd1);
            end
            if (n == 15) checkEq("ramp_state_c15", 32'(bus.stateDbg), 32'd1);
            if (n == 16) begin
                checkEq("ramp_gain_c16",  32'(bus.gainDbg),  32'd16);
                checkEq("ramp_state_c16", 32'(bus.stateDbg), 32'd2);
            end
        end

        // ---------------- rounding / saturation at full gain ----------------
        for (int i = 0; i < 6; i++) begin
            bus.dataIn       = vIn[i];
            bus.offsetBinary = vOb[i];
            expQ.push_back(vOut[i]);
            tick(); tick(); tick();
            checkEq("round_dataOut", 32'(bus.dataOut), expQ.pop_front());
            checkEq("round_satFlag", 32'(bus.satFlag), vSat[i]);
        end

        // ---------------- sticky flag ----------------
        bus.offsetBinary = 1'b0;
        bus.dataIn       = '0;
        tick(); tick();
        bus.clrSat = 1'b1;
        tick();
        bus.clrSat = 1'b0;
        checkEq("sticky_clear", 32'(bus.satFlag), 32'd0);
        bus.dataIn = 18'h1FFFF;
        tick();                       // sample enters stage 1
        bus.dataIn = '0;
        bus.clrSat = 1'b1;
        tick();                       // saturation and clear on the same edge
        checkEq("sticky_set_wins", 32'(bus.satFlag), 32'd1);
        tick();                       // clear alone
        checkEq("sticky_clr_alone", 32'(bus.satFlag), 32'd0);
        checkEq("sticky_dataOut",   32'(bus.dataOut), 32'h1FFF);
        bus.clrSat = 1'b0;

        // ---------------- half gain ----------------
        bus.mute = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        checkEq("half_gain8", 32'(bus.gainDbg), 32'd8);
        bus.dataIn = 18'h10000;  bus.mute = 1'b0;
        tick();                                  // sampled at g=8
        checkEq("half_gain9", 32'(bus.gainDbg), 32'd9);
        bus.dataIn = '0;         bus.mute = 1'b1;
        tick();                                  // sampled at g=9
        checkEq("half_gain8b", 32'(bus.gainDbg), 32'd8);
        bus.dataIn = 18'h30000;
        tick();                                  // sampled at g=8
        checkEq("half_pos", 32'(bus.dataOut), 32'h0800);
        bus.dataIn = '0;
        tick();
        checkEq("half_zero", 32'(bus.dataOut), 32'h0000);
        tick();
        checkEq("half_neg", 32'(bus.dataOut), 32'h3800);
        for (int i = 0; i < 5; i++) tick();
        checkEq("down_muted", 32'(bus.muted),    32'd1);
        checkEq("down_gain",  32'(bus.gainDbg),  32'd0);
        checkEq("down_state", 32'(bus.stateDbg), 32'd0);

        // ---------------- reversal at g=10 ----------------
        bus.mute = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checkEq("rev_gain10", 32'(bus.gainDbg), 32'd10);
        bus.mute = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            tick();
            checkEq("rev_gain",  32'(bus.gainDbg), 32'(i));
            checkEq("rev_muted", 32'(bus.muted),   (i == 0) ? 32'd1 : 32'd0);
        end

        // ---------------- async reset mid-ramp ----------------
        bus.dataIn = 18'h10000;
        bus.mute   = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checkEq("mid_gain7",   32'(bus.gainDbg), 32'd7);
        checkEq("mid_dataOut", 32'(bus.dataOut), 32'h0400);
        #2 resetN = 1'b0;
        #1;
        checkEq("async_dataOut", 32'(bus.dataOut), 32'h0);
        checkEq("async_muted",   32'(bus.muted),   32'd1);
        checkEq("async_gain",    32'(bus.gainDbg), 32'd0);
        bus.offsetBinary = 1'b1;
        tick();
        checkEq("held_gain", 32'(bus.gainDbg), 32'd0);
        resetN = 1'b1;
        tick();
        checkEq("rel_c1_dataOut", 32'(bus.dataOut), 32'h2000);
        checkEq("rel_c1_gain",    32'(bus.gainDbg), 32'd1);
        checkEq("rel_c1_muted",   32'(bus.muted),   32'd0);
        tick();
        checkEq("rel_c2_dataOut", 32'(bus.dataOut), 32'h2000);
        checkEq("rel_c2_gain",    32'(bus.gainDbg), 32'd2);
        tick();
        checkEq("rel_c3_dataOut", 32'(bus.dataOut), 32'h2000);
        tick();
        checkEq("rel_c4_dataOut", 32'(bus.dataOut), 32'h2100);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
